// File: rtl/dmem_mmio_unit_if.sv
// Bus between the MEM stage / console consumer and the data-memory unit.
// The unit side uses the slave modport; the driver of the MEM stage uses master.
interface dmem_mmio_unit_if;
    logic        mem_w;
    logic [2:0]  DMType;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        err_misalign;
    logic        err_overflow;

    modport slave (
        input  mem_w, DMType, addr, wdata, cons_ready,
        output rdata, cons_data, cons_valid, err_misalign, err_overflow
    );

    modport master (
        output mem_w, DMType, addr, wdata, cons_ready,
        input  rdata, cons_data, cons_valid, err_misalign, err_overflow
    );
endinterface

// File: rtl/dmem_mmio_unit.sv
// Data-memory stage: little-endian word RAM with sub-word access, plus an MMIO
// window holding a console TX FIFO, a free-running cycle counter and sticky status.
module dmem_mmio_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic              clk,
    input  logic              rstn,
    dmem_mmio_unit_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   r_mem  [DEPTH_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [FW-1:0] r_head;
    logic [FW-1:0] r_tail;
    logic [FW:0]   r_count;
    logic [31:0]   r_cycle;
    logic          r_errMisalign;
    logic          r_errOverflow;

    logic          w_isHalf;
    logic          w_isByte;
    logic          w_misalign;
    logic          w_inRam;
    logic          w_inMmio;
    logic          w_store;
    logic [AW-1:0] w_wordIdx;
    logic [13:0]   w_regSel;
    logic [3:0]    w_be;
    logic [31:0]   w_wLanes;
    logic          w_pushReq;
    logic          w_pushOk;
    logic          w_pop;
    logic          w_full;
    logic          w_consValid;
    logic          w_statusWr;
    logic          w_misalignSet;
    logic          w_overflowSet;
    logic [3:0]    w_cnt4;
    logic [31:0]   w_status;
    logic [31:0]   w_mmioWord;
    logic [31:0]   w_rawWord;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_rdata;

    // Access decode; any DMType outside the half/byte codes is treated as a word.
    always_comb begin
        w_isHalf   = (bus.DMType == 3'b001) || (bus.DMType == 3'b010);
        w_isByte   = (bus.DMType == 3'b011) || (bus.DMType == 3'b100);
        if (w_isHalf)
            w_misalign = bus.addr[0];
        else if (w_isByte)
            w_misalign = 1'b0;
        else
            w_misalign = (bus.addr[1:0] != 2'b00);
        w_inRam    = (bus.addr[31:AW+2] == '0);
        w_inMmio   = (bus.addr[31:16] == MMIO_BASE[31:16]);
        w_store    = bus.mem_w && !w_misalign;
        w_wordIdx  = bus.addr[AW+1:2];
        w_regSel   = bus.addr[15:2];
    end

    // Replicating the low store bytes across lanes lets each enabled lane pick
    // the byte matching its position within the access.
    always_comb begin
        w_be     = 4'b1111;
        w_wLanes = bus.wdata;
        if (w_isByte) begin
            w_be     = 4'b0001 << bus.addr[1:0];
            w_wLanes = {4{bus.wdata[7:0]}};
        end else if (w_isHalf) begin
            w_be     = bus.addr[1] ? 4'b1100 : 4'b0011;
            w_wLanes = {2{bus.wdata[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_store && w_inRam) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_wordIdx][8*i +: 8] <= w_wLanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_consValid   = (r_count != '0);
        w_full        = (r_count == (FW+1)'(FIFO_DEPTH));
        w_pop         = w_consValid && bus.cons_ready;
        w_pushReq     = w_store && w_inMmio && (w_regSel == 14'd0);
        w_pushOk      = w_pushReq && (!w_full || w_pop);
        w_statusWr    = w_store && w_inMmio && (w_regSel == 14'd2);
        w_misalignSet = bus.mem_w && w_misalign && (w_inRam || w_inMmio);
        w_overflowSet = w_pushReq && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_pushOk)
            r_fifo[r_tail] <= bus.wdata[7:0];
    end

    // Pointers are FW bits wide, so they wrap modulo FIFO_DEPTH on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk)
                r_tail <= r_tail + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (w_pushOk && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_pushOk && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // A set event in the same cycle as a software clear leaves the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle       <= '0;
            r_errMisalign <= 1'b0;
            r_errOverflow <= 1'b0;
        end else begin
            r_cycle       <= r_cycle + 32'd1;
            r_errMisalign <= w_misalignSet || (r_errMisalign && !(w_statusWr && bus.wdata[0]));
            r_errOverflow <= w_overflowSet || (r_errOverflow && !(w_statusWr && bus.wdata[1]));
        end
    end

    always_comb begin
        w_cnt4   = 4'(r_count);
        w_status = {19'b0, w_full, w_cnt4, 6'b0, r_errOverflow, r_errMisalign};
        case (w_regSel)
            14'd1:   w_mmioWord = r_cycle;
            14'd2:   w_mmioWord = w_status;
            default: w_mmioWord = 32'h0;
        endcase
    end

    // Loads share one lane-select/extension path for RAM and MMIO registers.
    always_comb begin
        if (w_inRam)
            w_rawWord = r_mem[w_wordIdx];
        else if (w_inMmio)
            w_rawWord = w_mmioWord;
        else
            w_rawWord = 32'h0;
        w_byte  = w_rawWord[8*bus.addr[1:0] +: 8];
        w_half  = bus.addr[1] ? w_rawWord[31:16] : w_rawWord[15:0];
        w_rdata = w_rawWord;
        case (bus.DMType)
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b010:  w_rdata = {16'h0, w_half};
            3'b011:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_rdata = {24'h0, w_byte};
            default: w_rdata = w_rawWord;
        endcase
        if (w_misalign || !(w_inRam || w_inMmio))
            w_rdata = 32'h0;
    end

    assign bus.rdata        = w_rdata;
    assign bus.cons_valid   = w_consValid;
    assign bus.cons_data    = w_consValid ? r_fifo[r_head] : 8'h00;
    assign bus.err_misalign = r_errMisalign;
    assign bus.err_overflow = r_errOverflow;

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Directed self-checking bench for dmem_mmio_unit: RAM sub-word access,
// alignment errors, console FIFO fill/drain/overflow, cycle counter and reset.
module tb_dmem_mmio_unit;

    localparam logic [31:0] CONS   = 32'hFFFF_0000;
    localparam logic [31:0] CYCLE  = 32'hFFFF_0004;
    localparam logic [31:0] STATUS = 32'hFFFF_0008;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    dmem_mmio_unit_if bus ();

    dmem_mmio_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        @(negedge clk);
        bus.addr   = a;
        bus.wdata  = d;
        bus.DMType = t;
        bus.mem_w  = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_w  = 1'b0;
    endtask

    task automatic doLoad(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
        bus.mem_w  = 1'b0;
        bus.addr   = a;
        bus.DMType = t;
        #1;
        d = bus.rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0;
        #3;
        total++;
        if (bus.cons_valid !== 1'b0 || bus.cons_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_fifo: got valid=%b data=%h expected valid=0 data=00", bus.cons_valid, bus.cons_data);
        end
        total++;
        if (bus.err_misalign !== 1'b0 || bus.err_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got mis=%b ovf=%b expected 0 0", bus.err_misalign, bus.err_overflow);
        end
        doLoad(STATUS, 3'b000, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_status: got %h expected 00000000", d);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_subword();
        logic [31:0] d;
        logic [31:0] exp [7];
        logic [31:0] adr [7];
        logic [2:0]  typ [7];
        doStore(32'h10, 32'h8899AABB, 3'b000);
        doStore(32'h12, 32'h0000007F, 3'b011);
        doStore(32'h14, 32'h00000000, 3'b000);
        doStore(32'h16, 32'h1234CAFE, 3'b010);
        adr = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h14, 32'h16};
        typ = '{3'b000, 3'b011, 3'b100, 3'b001, 3'b010, 3'b000, 3'b001};
        exp = '{32'h887FAABB, 32'hFFFFFF88, 32'h00000088, 32'hFFFF887F,
                32'h0000AABB, 32'hCAFE0000, 32'hFFFFCAFE};
        for (int i = 0; i < 7; i++) begin
            doLoad(adr[i], typ[i], d);
            total++;
            if (d !== exp[i]) begin
                bad++;
                $display("[TB] FAIL subword_load%0d addr=%h type=%b: got %h expected %h", i, adr[i], typ[i], d, exp[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        doStore(32'h0,  32'h00000000, 3'b000);
        doStore(32'h20, 32'h11223344, 3'b000);
        doStore(32'h21, 32'h12345678, 3'b000);
        doLoad(32'h20, 3'b000, d);
        total++;
        if (d !== 32'h11223344) begin
            bad++;
            $display("[TB] FAIL misalign_suppressed: got %h expected 11223344", d);
        end
        total++;
        if (bus.err_misalign !== 1'b1) begin
            bad++;
            $display("[TB] FAIL misalign_flag: got %b expected 1", bus.err_misalign);
        end
        doLoad(32'h21, 3'b000, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL misalign_load: got %h expected 00000000", d);
        end
        doLoad(STATUS, 3'b000, d);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("[TB] FAIL misalign_status: got %h expected 00000001", d);
        end
        doStore(STATUS + 32'h1, 32'h1, 3'b000);
        total++;
        if (bus.err_misalign !== 1'b1) begin
            bad++;
            $display("[TB] FAIL misaligned_clear_ignored: got %b expected 1", bus.err_misalign);
        end
        doStore(STATUS, 32'h1, 3'b000);
        total++;
        if (bus.err_misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL misalign_clear: got %b expected 0", bus.err_misalign);
        end
        doStore(32'h2000, 32'hDEADBEEF, 3'b000);
        doLoad(32'h2000, 3'b000, d);
        total++;
        if (d !== 32'h0 || bus.err_misalign !== 1'b0) begin
            bad++;
            $display("[TB] FAIL unmapped: got data=%h mis=%b expected 00000000 0", d, bus.err_misalign);
        end
        doLoad(32'h0, 3'b000, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("[TB] FAIL unmapped_alias: got %h expected 00000000", d);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        bus.cons_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            doStore(CONS, 32'h41 + i, 3'b000);
        doLoad(STATUS, 3'b000, d);
        total++;
        if (d !== 32'h00001802) begin
            bad++;
            $display("[TB] FAIL overflow_status: got %h expected 00001802", d);
        end
        total++;
        if (bus.cons_valid !== 1'b1 || bus.cons_data !== 8'h41 || bus.err_overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflow_head: got valid=%b data=%h ovf=%b expected 1 41 1", bus.cons_valid, bus.cons_data, bus.err_overflow);
        end
        @(negedge clk);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.cons_valid !== 1'b1 || bus.cons_data !== 8'(32'h41 + i)) begin
                bad++;
                $display("[TB] FAIL drain%0d: got valid=%b data=%h expected 1 %h", i, bus.cons_valid, bus.cons_data, 8'(32'h41 + i));
            end
            @(negedge clk);
        end
        total++;
        if (bus.cons_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drain_empty: got %b expected 0", bus.cons_valid);
        end
        bus.cons_ready = 1'b0;
        doStore(STATUS, 32'h2, 3'b000);
        total++;
        if (bus.err_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overflow_clear: got %b expected 0", bus.err_overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  exp [8];
        bus.cons_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            doStore(CONS, 32'h61 + i, 3'b000);
        @(negedge clk);
        bus.cons_ready = 1'b1;
        bus.addr       = CONS;
        bus.wdata      = 32'h5A;
        bus.DMType     = 3'b000;
        bus.mem_w      = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_w      = 1'b0;
        bus.cons_ready = 1'b0;
        doLoad(STATUS, 3'b000, d);
        total++;
        if (d !== 32'h00001800 || bus.err_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_pushpop_status: got %h ovf=%b expected 00001800 0", d, bus.err_overflow);
        end
        doLoad(STATUS + 32'h1, 3'b100, d);
        total++;
        if (d !== 32'h00000018) begin
            bad++;
            $display("[TB] FAIL status_lbu: got %h expected 00000018", d);
        end
        exp = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
        @(negedge clk);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.cons_valid !== 1'b1 || bus.cons_data !== exp[i]) begin
                bad++;
                $display("[TB] FAIL pushpop_drain%0d: got valid=%b data=%h expected 1 %h", i, bus.cons_valid, bus.cons_data, exp[i]);
            end
            @(negedge clk);
        end
        total++;
        if (bus.cons_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pushpop_empty: got %b expected 0", bus.cons_valid);
        end
        bus.cons_ready = 1'b0;
    endtask

    task automatic test_counter();
        logic [31:0] d;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        doLoad(CYCLE, 3'b000, d);
        total++;
        if (d < 32'd99 || d > 32'd101) begin
            bad++;
            $display("[TB] FAIL cycle_count: got %0d expected 100 +/-1", d);
        end
        doStore(CONS, 32'h33, 3'b000);
        doStore(32'h31, 32'h0, 3'b001);
        total++;
        if (bus.cons_valid !== 1'b1 || bus.err_misalign !== 1'b1) begin
            bad++;
            $display("[TB] FAIL prereset_state: got valid=%b mis=%b expected 1 1", bus.cons_valid, bus.err_misalign);
        end
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        doLoad(CYCLE, 3'b000, d);
        total++;
        if (d !== 32'h0 || bus.cons_valid !== 1'b0 || bus.err_misalign !== 1'b0 || bus.err_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got cycle=%h valid=%b mis=%b ovf=%b expected 0 0 0 0", d, bus.cons_valid, bus.err_misalign, bus.err_overflow);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rstn           = 1'b0;
        bus.mem_w      = 1'b0;
        bus.DMType     = 3'b000;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.cons_ready = 1'b0;
        test_reset();
        test_subword();
        test_misalign();
        test_fifo_overflow();
        test_back_to_back();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
